// File: rtl/nvm_access_ctrl.sv
// NVM array initiator: turns host read/program/erase requests into array cycles,
// with a write-protect gate and a valid/ready response. Optional macro: NVM_WRITE_VERIFY_EN.
module nvm_access_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0] ERASE_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  unlock,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [2:0]            dbg_state
);

  // Handshake: a request is taken on an edge with req_valid && req_ready (IDLE only);
  // a response is held on rsp_* while rsp_valid is high and retired on an edge with rsp_ready.

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

`ifdef NVM_WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_READ = 3'd1, S_WRITE = 3'd2, S_ERASE = 3'd3, S_VERIFY = 3'd4, S_RESP = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_READ = 3'd1, S_WRITE = 3'd2, S_ERASE = 3'd3, S_RESP = 3'd5
  } state_t;
`endif

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  busy_q, busy_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    busy_d        = busy_q;
    mem_we_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (req_op == OP_READ) begin
            mem_address_d = req_addr;
            state_d       = S_READ;
          end else if (req_op == OP_WRITE && unlock) begin
            mem_address_d = req_addr;
            mem_data_in_d = req_wdata;
            mem_we_d      = 1'b1;
            state_d       = S_WRITE;
          end else if (req_op == OP_ERASE && unlock) begin
            mem_address_d = '0;
            mem_data_in_d = ERASE_VALUE;
            mem_we_d      = 1'b1;
            state_d       = S_ERASE;
          end else begin
            // Locked program/erase or reserved opcode: reject without touching the array.
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_READ: begin
        rsp_rdata_d = mem_data_out;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_WRITE: begin
`ifdef NVM_WRITE_VERIFY_EN
        state_d = S_VERIFY;
`else
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
`endif
      end
`ifdef NVM_WRITE_VERIFY_EN
      S_VERIFY: begin
        if (mem_data_out != mem_data_in_q) begin
          rsp_error_d = 1'b1;
          rsp_rdata_d = mem_data_out;
        end
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
`endif
      S_ERASE: begin
        // The last location is written during the cycle that ends on this edge.
        if (&mem_address_q) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          mem_we_d      = 1'b1;
          mem_address_d = mem_address_q + ADDR_WIDTH'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      busy_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      busy_q        <= busy_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_error        = rsp_error_q;
  assign busy             = busy_q;
  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_address_q;
  assign mem_data_in      = mem_data_in_q;
  assign dbg_state        = state_q;

endmodule
